// File: rtl/mdu_pkg.sv
// MDU shared definitions: opcodes, FSM states and HI/LO read selects.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU opcodes.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;
    localparam logic [3:0] MDU_MF    = 4'd15;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_LO   = 2'b01;
    localparam logic [1:0] RD_HI   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result and div-by-zero flag.
// Ports: mduop/rs/rt in (hi/lo in with MDU_MADD_EN), res/dz out.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  mduop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MDU_MADD_EN
    input  logic [31:0] hi,
    input  logic [31:0] lo,
`endif
    output logic [63:0] res,
    output logic        dz
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rt_nz;
    logic [31:0] q_s, r_s;
    logic        ovf;

    assign prod_s = $signed({{32{rs[31]}}, rs}) *
                    $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Keep the divider free of x/0 and INT_MIN/-1 host traps.
    assign dz    = (rt == 32'd0);
    assign rt_nz = dz ? 32'd1 : rt;
    assign ovf   = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    always_comb begin
        q_s = 32'd0;
        r_s = 32'd0;
        if (ovf) begin
            q_s = 32'h8000_0000;
        end else begin
            q_s = $signed(rs) / $signed(rt_nz);
            r_s = $signed(rs) % $signed(rt_nz);
        end
    end

    always_comb begin
        res = 64'd0;
        case (mduop)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = {r_s, q_s};
            MDU_DIVU:  res = {rs % rt_nz, rs / rt_nz};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = {hi, lo} + prod_s;
            MDU_MADDU: res = {hi, lo} + prod_u;
            MDU_MSUB:  res = {hi, lo} - prod_s;
            MDU_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:   res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU sequencer: latency countdown, HI/LO ownership, D/F stall.
// Ports: start/mduop/operands/flush/md_in_d in; busy/stall_md/hilo_out/hi/lo out.
// MDU_MADD_EN adds the multiply-accumulate opcodes 7..10.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mduop,
    input  logic [1:0]  read_hilo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      res_hi, res_lo;
    logic             dz_q;
    logic [63:0]      res;
    logic             dz;
    logic             is_md, is_div;
    logic             issue, done, mt_ok;

    mdu_arith u_arith (
        .mduop (mduop),
        .rs    (rs_val),
        .rt    (rt_val),
`ifdef MDU_MADD_EN
        .hi    (hi),
        .lo    (lo),
`endif
        .res   (res),
        .dz    (dz)
    );

    assign is_div = (mduop == MDU_DIV) || (mduop == MDU_DIVU);

    always_comb begin
        is_md = 1'b0;
        case (mduop)
            MDU_MULT, MDU_MULTU,
            MDU_DIV, MDU_DIVU:   is_md = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU,
            MDU_MSUB, MDU_MSUBU: is_md = 1'b1;
`endif
            default:             is_md = 1'b0;
        endcase
    end

    assign issue = (state == ST_IDLE) & start & ~flush & is_md;
    assign mt_ok = (state == ST_IDLE) & ~flush;
    assign done  = (state == ST_RUN) & (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (issue) state_nx = ST_RUN;
            ST_RUN:  if (done)  state_nx = ST_IDLE;
            default:            state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            dz_q   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else if (issue) begin
            cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            res_hi <= res[63:32];
            res_lo <= res[31:0];
            // Only a divide can leave HI/LO untouched on a zero operand.
            dz_q   <= is_div & dz;
        end else if (state == ST_RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (done && !dz_q) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (mt_ok && mduop == MDU_MTHI) begin
            hi <= rs_val;
        end else if (mt_ok && mduop == MDU_MTLO) begin
            lo <= rs_val;
        end
    end

    assign stall_md = md_in_d & (busy | start);

    always_comb begin
        hilo_out = 32'd0;
        case (read_hilo)
            RD_HI:   hilo_out = hi;
            RD_LO:   hilo_out = lo;
            default: hilo_out = 32'd0;
        endcase
    end

endmodule
